reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
//  Write-back stage directly upstream of the register file write port. Merges ALU results
//  (valid/ready) and data-memory load results (valid only, never stalled) into the single
//  registered write port wr_en/wr_addr/dat_out. ALU results are buffered in a small in-order FIFO.
//  Also reports pending writes to one probe address, so decode can interlock or forward.
// PARAMETERS
//  PW     2   register address width (2**PW registers)
//  DW     8   data width
//  DEPTH  2   ALU result FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous active-low reset
//  alu_valid    in   1      ALU result present
//  alu_addr     in   PW     ALU destination register
//  alu_data     in   DW     ALU result
//  alu_ready    out  1      queue can accept ALU result this cycle
//  ld_valid     in   1      load result present (must be accepted this cycle)
//  ld_addr      in   PW     load destination register
//  ld_data      in   DW     load data
//  wr_en        out  1      register-file write enable (registered)
//  wr_addr      out  PW     register-file write address (registered)
//  dat_out      out  DW     register-file write data (registered)
//  hz_addr      in   PW     probe address from decode
//  hz_pending   out  1      a queued or in-flight write targets hz_addr
//  hz_fwd_data  out  DW     data of the youngest matching pending write (0 if none)
//  q_count      out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wr_en=0, wr_addr=0, dat_out=0, FIFO emptied, q_count=0.
//    Any queued entries are discarded. alu_ready=0 while rst_n=0. Reset mid-operation drops
//    everything, with no partial writes.
//  - Handshake: an ALU transfer occurs on a posedge with alu_valid&alu_ready.
//    alu_ready = rst_n & (q_count<DEPTH). It depends on registered count only; there is no
//    same-cycle pop credit.
//  - Output register, priority per posedge:
//    1) ld_valid: wr_en<=1, {wr_addr,dat_out}<=ld. The FIFO head stays. An ALU transfer enqueues.
//    2) else FIFO non-empty: pop head into the output register, wr_en<=1. An ALU transfer enqueues.
//    3) else FIFO empty and ALU transfer: bypass straight into the output register
//       (1-cycle latency), wr_en<=1. No enqueue.
//    4) else wr_en<=0. wr_addr/dat_out hold their last values.
//  - Latency: load = 1 cycle. ALU = 1 cycle (bypass) up to 1+q_count+ld cycles when queued.
//  - ALU results retire strictly in acceptance order. No ordering is guaranteed between the
//    load and ALU streams. Decode uses hz_pending to avoid WAW/RAW across streams.
//  - Full: with q_count==DEPTH, alu_ready=0. A sustained ld_valid starves the FIFO;
//    this is legal and there is no fairness guarantee.
//  - Simultaneous push+pop: count is unchanged, and pointers both advance mod DEPTH (wrap-around).
//  - Hazard (combinational): match set = valid FIFO entries plus the output register if wr_en=1.
//    hz_pending = any match. Youngest-match order is FIFO tail to head, then the output register.
//    hz_fwd_data = that entry's data.
//  - q_count never exceeds DEPTH and never underflows. The bench asserts this.
// STRUCTURE
//  - wb_pkg: typedef struct packed {logic[PW-1:0] addr; logic[DW-1:0] data;} wb_entry_t;
//    also the constants PW_DEF=2 and DW_DEF=8.
//  - Sub-module wb_fifo (DEPTH x wb_entry_t) with push/pop/count and an entry-array view.
//    The array view is exported for the hazard scan.
//  - Top level: priority mux, output register, hazard comparator tree.
// TESTING
//  1 Reset: drive traffic, pull rst_n=0 for 1 cycle -> wr_en=0, q_count=0, alu_ready=0 during
//    reset, and no write of the queued data afterwards.
//  2 ALU bypass: empty, alu{addr=2,data=8'h5A} -> next cycle wr_en=1, wr_addr=2, dat_out=8'h5A.
//  3 Load priority: ld{1,8'h11} and alu{3,8'h22} in the same cycle -> cycle1 write r1=11,
//    cycle2 write r3=22, q_count 1 then 0.
//  4 Full/backpressure: hold ld_valid 4 cycles while offering ALU {0,A0},{1,A1},{2,A2} ->
//    alu_ready drops after 2 accepts. After ld stops, writes are A0 then A1, then A2 is accepted.
//  5 Wrap: 6 back-to-back ALU results with ld pulses interleaved -> all 6 are written in order,
//    and pointers wrap with no loss or duplication.
//  6 Hazard: queue {2,33} then {2,44}, probe hz_addr=2 -> hz_pending=1, hz_fwd_data=8'h44.
//    Probe hz_addr=3 -> hz_pending=0, hz_fwd_data=0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared write-back entry type and default address/data widths
package wb_pkg;
  localparam int PW_DEF = 2;
  localparam int DW_DEF = 8;
  typedef struct packed {
    logic [PW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order entry FIFO; ports push/din, pop/head, count, age-ordered view ord/ord_v (index 0 = head)
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 2,
  parameter type T = wb_entry_t,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  output T                 head,
  output logic [CW-1:0]    count,
  output T                 ord [DEPTH],
  output logic [DEPTH-1:0] ord_v
);
  T mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr] <= din;
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rd];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord[i] = mem[rd + AW'(i)];
      ord_v[i] = CW'(i) < count;
    end
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: merges ALU (valid/ready, queued) and load (valid-only) results into a registered regfile write port, with hazard probe hz_addr -> hz_pending/hz_fwd_data and occupancy q_count
module reg_writeback_queue import wb_pkg::*; #(
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [PW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          ld_valid,
  input  logic [PW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          wr_en,
  output logic [PW-1:0] wr_addr,
  output logic [DW-1:0] dat_out,
  input  logic [PW-1:0] hz_addr,
  output logic          hz_pending,
  output logic [DW-1:0] hz_fwd_data,
  output logic [CW-1:0] q_count
);
  typedef struct packed {
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;
  entry_t head, nxt;
  entry_t ord [DEPTH];
  logic [DEPTH-1:0] ord_v;
  logic alu_fire, empty, push, pop, load_out;
  assign alu_ready = rst_n & (q_count < CW'(DEPTH));
  assign alu_fire = alu_valid & alu_ready;
  assign empty = q_count == '0;
  // an accepted ALU result queues only when the output slot is taken by a load or an older entry
  assign push = alu_fire & (ld_valid | !empty);
  assign pop = !ld_valid & !empty;
  assign load_out = ld_valid | !empty | alu_fire;
  assign nxt = ld_valid ? entry_t'({ld_addr, ld_data}) : !empty ? head : entry_t'({alu_addr, alu_data});
  wb_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .din(entry_t'({alu_addr, alu_data})),
    .pop(pop), .head(head), .count(q_count), .ord(ord), .ord_v(ord_v)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      dat_out <= '0;
    end else begin
      wr_en <= load_out;
      if (load_out) {wr_addr, dat_out} <= nxt;
    end
  end
  // oldest first so younger matches overwrite: output register, then FIFO head to tail
  always_comb begin
    hz_pending = wr_en & (wr_addr == hz_addr);
    hz_fwd_data = hz_pending ? dat_out : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_v[i] && ord[i].addr == hz_addr) begin
        hz_pending = 1'b1;
        hz_fwd_data = ord[i].data;
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed stimulus with per-stream scoreboards and immediate-assertion checks
module tb_reg_writeback_queue;
  localparam int PW = 2, DW = 8, DEPTH = 2, CW = $clog2(DEPTH + 1);
  logic clk = 0, rst_n = 0;
  logic alu_valid = 0, ld_valid = 0, alu_ready, wr_en, hz_pending;
  logic [PW-1:0] alu_addr = 0, ld_addr = 0, wr_addr, hz_addr = 0;
  logic [DW-1:0] alu_data = 0, ld_data = 0, dat_out, hz_fwd_data;
  logic [CW-1:0] q_count;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [PW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t alu_q[$], ld_q[$];
  logic ld_was = 0;

  reg_writeback_queue #(.PW(PW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .alu_ready(alu_ready), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_out(dat_out), .hz_addr(hz_addr),
    .hz_pending(hz_pending), .hz_fwd_data(hz_fwd_data), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Negedge: first score the write produced by the last posedge, then record what the next posedge will accept.
  always @(negedge clk) begin
    ent_t got, exp;
    logic have;
    got = '{wr_addr, dat_out};
    if (wr_en) begin
      have = ld_was ? ld_q.size() > 0 : alu_q.size() > 0;
      exp = !have ? 'x : ld_was ? ld_q.pop_front() : alu_q.pop_front();
      checks++;
      assert (have && got === exp) else begin
        errors++;
        $error("FAIL %s_write observed=%0h expected=%0h", ld_was ? "ld" : "alu", got, exp);
      end
    end
    checks++;
    assert (q_count <= CW'(DEPTH)) else begin
      errors++;
      $error("FAIL q_count_bound observed=%0d expected<=%0d", q_count, DEPTH);
    end
    if (!rst_n) begin
      alu_q.delete();
      ld_q.delete();
      ld_was = 0;
    end else begin
      if (alu_valid && alu_ready) alu_q.push_back('{alu_addr, alu_data});
      if (ld_valid) ld_q.push_back('{ld_addr, ld_data});
      ld_was = ld_valid;
    end
  end

  initial begin
    int idx;
    logic acc;
    repeat (2) tick;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_alu_ready", alu_ready, 0);
    rst_n = 1;
    tick;
    // ALU bypass
    alu_valid = 1; alu_addr = 2; alu_data = 8'h5A;
    chk("byp_ready", alu_ready, 1);
    tick;
    alu_valid = 0;
    chk("byp_wr_en", wr_en, 1);
    chk("byp_wr_addr", wr_addr, 2);
    chk("byp_dat_out", dat_out, 8'h5A);
    chk("byp_q_count", q_count, 0);
    tick;
    chk("idle_wr_en", wr_en, 0);
    chk("idle_dat_hold", dat_out, 8'h5A);
    // load priority over a simultaneous ALU result
    ld_valid = 1; ld_addr = 1; ld_data = 8'h11;
    alu_valid = 1; alu_addr = 3; alu_data = 8'h22;
    tick;
    ld_valid = 0; alu_valid = 0;
    chk("pri_c1_addr", wr_addr, 1);
    chk("pri_c1_data", dat_out, 8'h11);
    chk("pri_c1_cnt", q_count, 1);
    tick;
    chk("pri_c2_addr", wr_addr, 3);
    chk("pri_c2_data", dat_out, 8'h22);
    chk("pri_c2_cnt", q_count, 0);
    tick;
    // full / backpressure under sustained loads
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      ld_valid = c < 4; ld_addr = 3; ld_data = 8'hD0 + 8'(c);
      alu_valid = 1; alu_addr = PW'(idx); alu_data = 8'hA0 + 8'(idx);
      if (c == 2) chk("full_ready", alu_ready, 0);
      if (c == 2) chk("full_cnt", q_count, 2);
      acc = alu_ready;
      tick;
      if (acc) idx++;
      if (c == 3) chk("full_accepts", idx, 2);
    end
    alu_valid = 0; ld_valid = 0;
    chk("full_all_acc", idx, 3);
    repeat (3) tick;
    chk("full_drained", q_count, 0);
    // wrap: six ALU results with interleaved load pulses
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      ld_valid = c[0] && c < 8; ld_addr = 0; ld_data = 8'hC0 + 8'(c);
      alu_valid = 1; alu_addr = PW'(idx); alu_data = 8'hB0 + 8'(idx);
      acc = alu_ready;
      tick;
      if (acc) idx++;
    end
    alu_valid = 0; ld_valid = 0;
    chk("wrap_all_acc", idx, 6);
    repeat (3) tick;
    chk("wrap_drained", q_count, 0);
    chk("wrap_sb_empty", alu_q.size(), 0);
    // hazard probe with two queued writes to r2
    ld_valid = 1; ld_addr = 1; ld_data = 8'h01;
    alu_valid = 1; alu_addr = 2; alu_data = 8'h33;
    tick;
    ld_data = 8'h02; alu_data = 8'h44;
    tick;
    ld_data = 8'h03; alu_valid = 0;
    chk("hz_cnt", q_count, 2);
    hz_addr = 2; #1;
    chk("hz2_pending", hz_pending, 1);
    chk("hz2_fwd", hz_fwd_data, 8'h44);
    hz_addr = 3; #1;
    chk("hz3_pending", hz_pending, 0);
    chk("hz3_fwd", hz_fwd_data, 0);
    hz_addr = 1; #1;
    chk("hz1_pending", hz_pending, 1);
    chk("hz1_fwd", hz_fwd_data, 8'h02);
    tick;
    ld_valid = 0;
    repeat (3) tick;
    chk("hz_drained", q_count, 0);
    hz_addr = 2; #1;
    chk("hz_clear", hz_pending, 0);
    // reset mid-operation drops queued entries
    ld_valid = 1; ld_addr = 0; ld_data = 8'hE0;
    alu_valid = 1; alu_addr = 1; alu_data = 8'hE1;
    tick;
    ld_data = 8'hE8; alu_addr = 2; alu_data = 8'hE2;
    tick;
    chk("mid_cnt", q_count, 2);
    ld_valid = 0; alu_addr = 3; alu_data = 8'hE3;
    rst_n = 0; #1;
    chk("mid_rst_ready", alu_ready, 0);
    tick;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_cnt", q_count, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", dat_out, 0);
    rst_n = 1; alu_valid = 0;
    repeat (4) tick;
    chk("post_rst_wr_en", wr_en, 0);
    chk("sb_alu_empty", alu_q.size(), 0);
    chk("sb_ld_empty", ld_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
